// File: rtl/cc_display.sv
// Six-digit multiplexed 7-segment driver for the clock core: glitch-filtered
// digit capture, digit scanning, leading-zero blanking, alarm blink and a sticky error flag.
module cc_display #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 250000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       H1,
   input  logic [3:0] H2,
   input  logic [2:0] M1,
   input  logic [3:0] M2,
   input  logic [2:0] S1,
   input  logic [3:0] S2,
   input  logic       led_alarm,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       dp,
   output logic       err
);

   localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h7E;
         4'd1:    s = 7'h30;
         4'd2:    s = 7'h6D;
         4'd3:    s = 7'h79;
         4'd4:    s = 7'h33;
         4'd5:    s = 7'h5B;
         4'd6:    s = 7'h5F;
         4'd7:    s = 7'h70;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h7B;
         default: s = 7'h01;
      endcase
      return s;
   endfunction

   logic [18:0]        din;
   logic [18:0]        sample;
   logic [18:0]        shadow;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [2:0]         idx;
   logic [BLINK_W-1:0] blink_cnt;
   logic               phase;

   logic               sh_h1;
   logic [3:0]         sh_h2;
   logic [2:0]         sh_m1;
   logic [3:0]         sh_m2;
   logic [2:0]         sh_s1;
   logic [3:0]         sh_s2;

   logic [3:0]         digit;
   logic               digit_bad;
   logic               lz_blank;
   logic               any_bad;
   logic               scan_wrap;
   logic [6:0]         seg_next;
   logic [5:0]         an_next;
   logic               dp_next;

   assign din = {H1, H2, M1, M2, S1, S2};
   assign {sh_h1, sh_h2, sh_m1, sh_m2, sh_s1, sh_s2} = shadow;

   // The shadow only follows inputs that held the same value across two edges,
   // so a digit caught mid-update by the clock core never reaches the display.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample <= '0;
         shadow <= '0;
      end else begin
         sample <= din;
         if (din == sample)
            shadow <= din;
      end
   end

   assign scan_wrap = (scan_cnt == SCAN_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         idx      <= 3'd0;
      end else if (scan_wrap) begin
         scan_cnt <= '0;
         idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Blink timing runs only while the alarm is active; dropping the alarm
   // restarts it from a visible phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (!led_alarm) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   always_comb begin
      digit     = 4'd0;
      digit_bad = 1'b0;
      lz_blank  = 1'b0;
      case (idx)
         3'd0: begin
            digit     = sh_s2;
            digit_bad = (sh_s2 > 4'd9);
         end
         3'd1: begin
            digit     = {1'b0, sh_s1};
            digit_bad = (sh_s1 > 3'd5);
         end
         3'd2: begin
            digit     = sh_m2;
            digit_bad = (sh_m2 > 4'd9);
         end
         3'd3: begin
            digit     = {1'b0, sh_m1};
            digit_bad = (sh_m1 > 3'd5);
         end
         3'd4: begin
            digit     = sh_h2;
            digit_bad = (sh_h2 > 4'd9);
         end
         3'd5: begin
            digit    = {3'b000, sh_h1};
            lz_blank = ~sh_h1;
         end
         default: ;
      endcase

      seg_next = digit_bad ? 7'h01 : seg_decode(digit);
      if (lz_blank)
         seg_next = 7'h00;
      an_next = ~(6'b000001 << idx);
      dp_next = (idx == 3'd2) || (idx == 3'd4);
   end

   assign any_bad = (sh_s2 > 4'd9) || (sh_s1 > 3'd5) || (sh_m2 > 4'd9) ||
                    (sh_m1 > 3'd5) || (sh_h2 > 4'd9);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= 7'h00;
         an  <= 6'h3F;
         dp  <= 1'b0;
         err <= 1'b0;
      end else begin
         if (phase) begin
            seg <= 7'h00;
            an  <= 6'h3F;
            dp  <= 1'b0;
         end else begin
            seg <= seg_next;
            an  <= an_next;
            dp  <= dp_next;
         end
         err <= err | any_bad;
      end
   end

endmodule

// File: tb/tb_cc_display.sv
// Directed bench for cc_display: a reference model pushes the expected display
// word for every checked edge, and the stimulus sequence pops and compares it.
module tb_cc_display;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       H1 = 1'b0;
   logic [3:0] H2 = 4'd0;
   logic [2:0] M1 = 3'd0;
   logic [3:0] M2 = 4'd0;
   logic [2:0] S1 = 3'd0;
   logic [3:0] S2 = 4'd0;
   logic       led_alarm = 1'b0;
   logic [6:0] seg;
   logic [5:0] an;
   logic       dp;
   logic       err;

   int n_tests = 0;
   int n_fail  = 0;

   // digits the display is expected to show once the inputs have settled
   int e_h1 = 0, e_h2 = 0, e_m1 = 0, e_m2 = 0, e_s1 = 0, e_s2 = 0;

   int   m_idx = 0, m_cnt = 0, m_bcnt = 0;
   logic m_phase = 1'b0;
   logic chk_en = 1'b0;
   // {blanked, an[5:0], seg[6:0], dp}
   logic [14:0] exp_q[$];

   cc_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .clk(clk), .reset(reset),
      .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
      .led_alarm(led_alarm),
      .seg(seg), .an(an), .dp(dp), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] dec(input int v);
      case (v)
         0: return 7'h7E;
         1: return 7'h30;
         2: return 7'h6D;
         3: return 7'h79;
         4: return 7'h33;
         5: return 7'h5B;
         6: return 7'h5F;
         7: return 7'h70;
         8: return 7'h7F;
         9: return 7'h7B;
         default: return 7'h01;
      endcase
   endfunction

   function automatic logic [6:0] digit_seg(input int i);
      case (i)
         0: return (e_s2 > 9) ? 7'h01 : dec(e_s2);
         1: return (e_s1 > 5) ? 7'h01 : dec(e_s1);
         2: return (e_m2 > 9) ? 7'h01 : dec(e_m2);
         3: return (e_m1 > 5) ? 7'h01 : dec(e_m1);
         4: return (e_h2 > 9) ? 7'h01 : dec(e_h2);
         default: return (e_h1 == 0) ? 7'h00 : 7'h30;
      endcase
   endfunction

   function automatic logic [14:0] model_out(input int i, input logic ph);
      logic [5:0] a;
      logic       d;
      if (ph)
         return {1'b1, 6'h3F, 7'h00, 1'b0};
      a = 6'h3F ^ (6'd1 << i);
      d = (i == 2) || (i == 4);
      return {1'b0, a, digit_seg(i), d};
   endfunction

   // Reference timing: the word after an edge reflects digit index and blink
   // phase as they stood before that edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_idx   = 0;
         m_cnt   = 0;
         m_bcnt  = 0;
         m_phase = 1'b0;
      end else begin
         if (chk_en)
            exp_q.push_back(model_out(m_idx, m_phase));
         if (m_cnt == SCAN_DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx == 5) ? 0 : m_idx + 1;
         end else begin
            m_cnt = m_cnt + 1;
         end
         if (led_alarm) begin
            if (m_bcnt == BLINK_DIV - 1) begin
               m_bcnt  = 0;
               m_phase = ~m_phase;
            end else begin
               m_bcnt = m_bcnt + 1;
            end
         end else begin
            m_bcnt  = 0;
            m_phase = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_check(input int n, input string tag);
      logic [14:0] w;
      chk_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: no expected entry at cycle %0d", tag, i);
         end else begin
            w = exp_q.pop_front();
            chk({tag, "_an"}, 16'(an), 16'(w[13:8]));
            chk({tag, "_dp"}, 16'(dp), 16'(w[0]));
            if (!w[14])
               chk({tag, "_seg"}, 16'(seg), 16'(w[7:1]));
         end
      end
      chk_en = 1'b0;
   endtask

   task automatic set_digits(input int h1, input int h2, input int m1,
                             input int m2, input int s1, input int s2);
      H1 = h1[0];
      H2 = h2[3:0];
      M1 = m1[2:0];
      M2 = m2[3:0];
      S1 = s1[2:0];
      S2 = s2[3:0];
      e_h1 = h1; e_h2 = h2; e_m1 = m1; e_m2 = m2; e_s1 = s1; e_s2 = s2;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_model(input int i, input int c);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge clk);
         if (m_idx == i && m_cnt == c)
            found = 1'b1;
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $error("FAIL wait_model: idx %0d cnt %0d not reached, required idx %0d cnt %0d",
                m_idx, m_cnt, i, c);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an",  16'(an),  16'h003F);
      chk("rst_seg", 16'(seg), 16'h0000);
      chk("rst_dp",  16'(dp),  16'h0000);
      chk("rst_err", 16'(err), 16'h0000);

      // all-zero inputs match the reset shadow, so the first edge is checkable
      @(negedge clk);
      reset = 1'b0;
      run_check(24, "scan_zero");

      set_digits(1, 2, 3, 4, 5, 9);
      run_check(48, "scan_123459");

      set_digits(0, 9, 0, 0, 0, 0);
      run_check(24, "lz_blank");

      // one-cycle glitch on S2 while the seconds digit is being shown
      set_digits(1, 2, 3, 4, 5, 9);
      wait_model(0, 0);
      S2 = 4'd0;
      run_check(1, "glitch");
      S2 = 4'd9;
      run_check(24, "glitch_hold");
      chk("err_clean", 16'(err), 16'h0000);

      // S2 = 12 held for three edges
      S2 = 4'd12;
      repeat (3) @(posedge clk);
      #1;
      set_digits(1, 2, 3, 4, 5, 0);
      chk("err_set", 16'(err), 16'h0001);
      run_check(24, "after_bad");
      chk("err_sticky", 16'(err), 16'h0001);

      set_digits(1, 2, 3, 4, 5, 12);
      run_check(24, "dash");
      chk("err_dash", 16'(err), 16'h0001);

      set_digits(1, 2, 3, 4, 5, 9);
      led_alarm = 1'b1;
      run_check(54, "blink");
      // blink phase is blanked here; the display must reappear one edge later
      led_alarm = 1'b0;
      run_check(8, "unblink");

      set_digits(0, 0, 0, 0, 0, 0);
      wait_model(3, 2);
      chk("pre_rst_an", 16'(an), 16'h0037);
      reset = 1'b1;
      #1;
      chk("mid_rst_an",  16'(an),  16'h003F);
      chk("mid_rst_seg", 16'(seg), 16'h0000);
      chk("mid_rst_dp",  16'(dp),  16'h0000);
      chk("mid_rst_err", 16'(err), 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_an", 16'(an), 16'h003F);
      @(negedge clk);
      reset = 1'b0;
      run_check(24, "restart");
      chk("err_after_rst", 16'(err), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
